// File: rtl/cic_interp_wrap.sv
// cic_interp_wrap: CIC interpolator, one low-rate sample per R clocks in, R high-rate samples out
// Ports: clk; rst async active-low; i_data/val_in low-rate input and strobe;
//        val_out/o_data_trunc high-rate output and strobe; ovr sticky overrun flag
module cic_interp_wrap #(
  parameter int Win   = 16,
  parameter int N     = 3,
  parameter int LOG2R = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Win-1:0] i_data,
  input  logic           val_in,
  output logic           val_out,
  output logic [15:0]    o_data_trunc,
  output logic           ovr
);
  localparam int W  = Win + N * LOG2R;
  localparam int R  = 1 << LOG2R;
  localparam int PW = LOG2R + 1;
  localparam int SH = (N - 1) * LOG2R;
  localparam logic signed [W-1:0] MAXV = W'(32767);
  localparam logic signed [W-1:0] MINV = -W'(32768);
  logic [Win-1:0]        din_q;
  logic                  vin_q;
  logic [PW-1:0]         ph_q, ph_d;
  logic signed [W-1:0]   dly_q [N];
  logic signed [W-1:0]   integ_q [N];
  logic signed [W-1:0]   c [N+1];
  logic signed [W-1:0]   x_q, xs, sh;
  logic [15:0]           sat;
  logic                  acc, adv, adv_q;
  always_comb begin
    c[0] = {{(W-Win){din_q[Win-1]}}, din_q};
    for (int k = 1; k <= N; k++) c[k] = c[k-1] - dly_q[k-1];
    acc  = vin_q && (ph_q <= PW'(1));
    adv  = ph_q != '0;
    ph_d = acc ? PW'(R) : adv ? ph_q - PW'(1) : ph_q;
    // zero stuffing: the comb output enters only on the first step of a burst
    xs   = (ph_q == PW'(R)) ? x_q : '0;
    // the shift removes the R**(N-1) DC gain of the chain
    sh   = integ_q[N-1] >>> SH;
    sat  = (sh > MAXV) ? 16'h7fff : (sh < MINV) ? 16'h8000 : sh[15:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q        <= '0;
      vin_q        <= 1'b0;
      ph_q         <= '0;
      x_q          <= '0;
      adv_q        <= 1'b0;
      val_out      <= 1'b0;
      o_data_trunc <= '0;
      ovr          <= 1'b0;
      for (int k = 0; k < N; k++) begin
        dly_q[k]   <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      din_q   <= i_data;
      vin_q   <= val_in;
      ph_q    <= ph_d;
      adv_q   <= adv;
      val_out <= adv_q;
      if (acc) begin
        for (int k = 0; k < N; k++) dly_q[k] <= c[k];
        x_q <= c[N];
      end
      if (vin_q && ph_q > PW'(1)) ovr <= 1'b1;
      // integrators are pipelined: each stage adds the previous stage's old value
      if (adv) begin
        integ_q[0] <= integ_q[0] + xs;
        for (int k = 1; k < N; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
      if (adv_q) o_data_trunc <= sat;
    end
  end
endmodule

// File: tb/tb_cic_interp_wrap.sv
// tb_cic_interp_wrap: randomized checks of cic_interp_wrap against a convolution model
module tb_cic_interp_wrap;
  logic        clk = 1'b0, rst = 1'b0, val_in = 1'b0;
  logic [15:0] i_data = '0;
  logic        val_out, ovr;
  logic [15:0] o_data_trunc;
  int checks = 0, errors = 0, cyc = 0;
  int h [22];
  int stim [$];
  int got [$];
  int gcyc [$];
  int dc_ref [$];

  always #5 clk = ~clk;

  cic_interp_wrap dut (
    .clk(clk), .rst(rst), .i_data(i_data), .val_in(val_in),
    .val_out(val_out), .o_data_trunc(o_data_trunc), .ovr(ovr)
  );

  always @(negedge clk) begin
    cyc++;
    if (val_out) begin
      got.push_back(int'($signed(o_data_trunc)));
      gcyc.push_back(cyc);
    end
  end

  // output m = (x upsampled by 8) convolved with (1+z+..+z^7)^3, delayed by 2, /64, clamped
  function automatic int expect_y(int m);
    longint a = 0;
    for (int k = 0; k < 22; k++) begin
      int p = m - 2 - k;
      if (p >= 0 && p % 8 == 0 && p / 8 < stim.size()) a += longint'(h[k]) * stim[p/8];
    end
    a = a >>> 6;
    return (a > 32767) ? 32767 : (a < -32768) ? -32768 : int'(a);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    val_in = 1'b0;
    repeat (3) @(negedge clk);
    got.delete();
    gcyc.delete();
    rst = 1'b1;
  endtask

  task automatic drive(int spacing);
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      i_data = 16'(stim[i]);
      val_in = 1'b1;
      repeat (spacing - 1) begin
        @(negedge clk);
        val_in = 1'b0;
        i_data = 16'($urandom);
      end
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      val_in = 1'($urandom);
      i_data = 16'($urandom);
      checks++;
      if ({val_out, o_data_trunc, ovr} !== 18'd0) begin
        errors++;
        $display("FAIL reset_hold got vo=%b d=%0d ovr=%b exp 0 0 0", val_out, o_data_trunc, ovr);
      end
    end
    val_in = 1'b0;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (val_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got vo=%b exp 0", val_out);
      end
    end
  endtask

  task automatic test_stream(string name, int spacing);
    do_reset();
    drive(spacing);
    checks++;
    if (got.size() != 8 * stim.size()) begin
      errors++;
      $display("FAIL %s_count got %0d exp %0d", name, got.size(), 8 * stim.size());
    end
    for (int i = 0; i < got.size() && i < 8 * stim.size(); i++) begin
      checks++;
      if (got[i] !== expect_y(i)) begin
        errors++;
        $display("FAIL %s_data[%0d] got %0d exp %0d", name, i, got[i], expect_y(i));
      end
    end
    for (int i = 0; i + 1 < gcyc.size(); i++) begin
      checks++;
      if (gcyc[i+1] - gcyc[i] !== ((i % 8 == 7) ? spacing - 7 : 1)) begin
        errors++;
        $display("FAIL %s_spacing[%0d] got %0d exp %0d", name, i, gcyc[i+1] - gcyc[i],
                 (i % 8 == 7) ? spacing - 7 : 1);
      end
    end
  endtask

  task automatic test_dc(int v, int spacing);
    stim.delete();
    repeat (8) stim.push_back(v);
    test_stream($sformatf("dc%0d", v), spacing);
    checks++;
    if (got.size() == 0 || got[got.size()-1] !== v) begin
      errors++;
      $display("FAIL dc_settle got %0d exp %0d", got.size() ? got[got.size()-1] : 0, v);
    end
  endtask

  task automatic test_impulse();
    int nz = 0, sum = 0, peak = 0;
    stim = '{64, 0, 0, 0};
    test_stream("impulse", 8);
    foreach (got[i]) begin
      if (got[i] != 0) nz++;
      sum += got[i];
      if (got[i] > peak) peak = got[i];
    end
    checks++;
    if (nz !== 22) begin errors++; $display("FAIL impulse_nonzero got %0d exp 22", nz); end
    checks++;
    if (sum !== 512) begin errors++; $display("FAIL impulse_sum got %0d exp 512", sum); end
    checks++;
    if (peak !== 48) begin errors++; $display("FAIL impulse_peak got %0d exp 48", peak); end
    for (int i = 0; i < 22 && i + 2 < got.size(); i++) begin
      checks++;
      if (got[i+2] !== h[i]) begin
        errors++;
        $display("FAIL impulse_shape[%0d] got %0d exp %0d", i, got[i+2], h[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      repeat (10) stim.push_back(int'($signed(16'($urandom))));
      test_stream($sformatf("rand%0d", r), int'($urandom_range(8, 12)));
    end
  endtask

  task automatic test_overrun();
    do_reset();
    stim = '{int'($signed(16'($urandom)))};
    @(negedge clk);
    i_data = 16'(stim[0]);
    val_in = 1'b1;
    @(negedge clk);
    i_data = 16'($urandom);
    @(negedge clk);
    val_in = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (got.size() !== 8) begin errors++; $display("FAIL overrun_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] !== expect_y(i)) begin
        errors++;
        $display("FAIL overrun_data[%0d] got %0d exp %0d", i, got[i], expect_y(i));
      end
    end
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", ovr); end
    repeat (30) @(negedge clk);
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", ovr); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int t = 0; t < 100 && n < 4; t++) begin
      @(negedge clk);
      val_in = (t % 8 == 0);
      i_data = 16'd1000;
      if (val_out) n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL midreset_wait got %0d pulses exp 4", n); end
    rst = 1'b0;
    #1;
    checks++;
    if ({val_out, o_data_trunc, ovr} !== 18'd0) begin
      errors++;
      $display("FAIL midreset_async got vo=%b d=%0d ovr=%b exp 0 0 0", val_out, o_data_trunc, ovr);
    end
    test_dc(1000, 8);
    for (int i = 0; i < got.size() && i < dc_ref.size(); i++) begin
      checks++;
      if (got[i] !== dc_ref[i]) begin
        errors++;
        $display("FAIL midreset_reconverge[%0d] got %0d exp %0d", i, got[i], dc_ref[i]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 22; s++) begin
      h[s] = 0;
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < 8; c++)
            if (a + b + c == s) h[s]++;
    end
    test_reset();
    test_dc(1000, 8);
    dc_ref = got;
    test_dc(-32768, 8);
    test_dc(32767, 8);
    test_impulse();
    test_overrun();
    test_dc(500, 13);
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
